// File: rtl/elevator_motion_ctrl.sv
// Car motion controller: walks the car floor by floor toward a latched target,
// opens the door on arrival and pulses a clear for the served floor request.
module elevator_motion_ctrl #(
  parameter logic [1:0]  labelF1       = 2'b00,
  parameter logic [1:0]  labelF2       = 2'b01,
  parameter logic [1:0]  labelF3       = 2'b10,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gf,
  input  logic       led1,
  input  logic       led2,
  input  logic       led3,
  output logic [1:0] floor,
  output logic       move_handler,
  output logic       up,
  output logic       down,
  output logic       door_open,
  output logic       clr1,
  output logic       clr2,
  output logic       clr3
);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       floor_q, floor_d;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic       led_here;
  logic       any_led;
  logic       gf_valid;
  logic       going_up;
  logic [1:0] floor_step;

  always_comb begin
    led_here = 1'b0;
    if (floor_q == labelF1) led_here = led1;
    if (floor_q == labelF2) led_here = led2;
    if (floor_q == labelF3) led_here = led3;
  end

  assign any_led  = led1 | led2 | led3;
  assign gf_valid = (gf == labelF1) || (gf == labelF2) || (gf == labelF3);
  assign going_up = target_q > floor_q;

  // Saturate at the end floors so a corrupted target can never wrap the car.
  always_comb begin
    floor_step = floor_q;
    if (going_up) begin
      if (floor_q != labelF3) floor_step = floor_q + 2'd1;
    end else begin
      if (floor_q != labelF1) floor_step = floor_q - 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    target_d = target_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (led_here) begin
          state_d = DOOR;
          timer_d = '0;
        end else if (any_led && gf_valid && (gf != floor_q)) begin
          state_d  = MOVING;
          target_d = gf;
          timer_d  = '0;
        end
      end
      MOVING: begin
        if (timer_q == TRAVEL_LAST) begin
          floor_d = floor_step;
          timer_d = '0;
          if (floor_step == target_q) state_d = DOOR;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      DOOR: begin
        // A fresh request here after the clear cycle restarts the door period.
        if ((timer_q != '0) && led_here) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      floor_q  <= labelF1;
      target_q <= labelF1;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      target_q <= target_d;
      timer_q  <= timer_d;
    end
  end

  assign floor        = floor_q;
  assign move_handler = state_q != IDLE;
  assign up           = (state_q == MOVING) && going_up;
  assign down         = (state_q == MOVING) && !going_up;
  assign door_open    = state_q == DOOR;
  assign clr1         = (state_q == DOOR) && (timer_q == '0) && (floor_q == labelF1);
  assign clr2         = (state_q == DOOR) && (timer_q == '0) && (floor_q == labelF2);
  assign clr3         = (state_q == DOOR) && (timer_q == '0) && (floor_q == labelF3);

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a trip-level model.
module tb_elevator_motion_ctrl;

  localparam int TRAVEL = 4;
  localparam int DOORC  = 3;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gf = 2'd0;
  logic [2:0] led = 3'b000;
  logic [1:0] floor;
  logic       move_handler, up, down, door_open, clr1, clr2, clr3;
  logic [2:0] clr;

  int  checks = 0;
  int  failures = 0;
  bit  check_en = 1'b0;

  int m_mode = M_IDLE;
  int m_floor = 0;
  int m_start = 0;
  int m_target = 0;
  int m_elapsed = 0;
  int m_age = 0;

  always #5 clk = ~clk;

  assign clr = {clr3, clr2, clr1};

  elevator_motion_ctrl #(
    .labelF1(2'b00),
    .labelF2(2'b01),
    .labelF3(2'b10),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DOORC),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gf(gf),
    .led1(led[0]),
    .led2(led[1]),
    .led3(led[2]),
    .floor(floor),
    .move_handler(move_handler),
    .up(up),
    .down(down),
    .door_open(door_open),
    .clr1(clr1),
    .clr2(clr2),
    .clr3(clr3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trip_len();
    return (m_target > m_start) ? (m_target - m_start) * TRAVEL
                                : (m_start - m_target) * TRAVEL;
  endfunction

  function automatic int exp_floor();
    if (m_mode != M_MOVE) return m_floor;
    if (m_target > m_start) return m_start + m_elapsed / TRAVEL;
    return m_start - m_elapsed / TRAVEL;
  endfunction

  function automatic int exp_clr();
    if (m_mode == M_DOOR && m_age == 0) return 1 << m_floor;
    return 0;
  endfunction

  // Trip-level model: a move is a start, a target and elapsed cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_floor <= 0; m_start <= 0; m_target <= 0;
      m_elapsed <= 0; m_age <= 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (led[m_floor]) begin
            m_mode <= M_DOOR; m_age <= 0;
          end else if (led != 3'b000 && gf != 2'd3 && int'(gf) != m_floor) begin
            m_mode <= M_MOVE; m_start <= m_floor; m_target <= int'(gf);
            m_elapsed <= 0;
          end
        end
        M_MOVE: begin
          if (m_elapsed + 1 == trip_len()) begin
            m_floor <= m_target; m_mode <= M_DOOR; m_age <= 0;
          end else begin
            m_elapsed <= m_elapsed + 1;
          end
        end
        default: begin
          if (m_age > 0 && led[m_floor]) m_age <= 0;
          else if (m_age == DOORC - 1) m_mode <= M_IDLE;
          else m_age <= m_age + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_floor", int'(floor), exp_floor());
      chk("cmp_move_handler", int'(move_handler), int'(m_mode != M_IDLE));
      chk("cmp_up", int'(up), int'(m_mode == M_MOVE && m_target > m_start));
      chk("cmp_down", int'(down), int'(m_mode == M_MOVE && m_target < m_start));
      chk("cmp_door_open", int'(door_open), int'(m_mode == M_DOOR));
      chk("cmp_clr", int'(clr), exp_clr());
    end
  end

  // One cycle; the upstream selector drops a request as soon as its clear shows.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (clr[k]) led[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    led = 3'b000;
    gf = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    check_en = 1'b1;

    // Reset state and first cycle after reset
    do_reset();
    chk("rst_floor", int'(floor), 0);
    chk("rst_mh", int'(move_handler), 0);
    chk("rst_outs", int'({up, down, door_open, clr}), 0);

    // F1 -> F3 with request at F3
    led[2] = 1'b1; gf = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_up", int'(up), 1);
      chk("t2_floor", int'(floor), (i < 4) ? 0 : 1);
      chk("t2_no_door", int'(door_open), 0);
    end
    tick();
    chk("t2_arrive_floor", int'(floor), 2);
    chk("t2_door", int'(door_open), 1);
    chk("t2_clr3", int'(clr), 4);
    chk("t2_up_off", int'(up), 0);
    tick();
    chk("t2_door2", int'(door_open), 1);
    chk("t2_clr_once", int'(clr), 0);
    tick();
    chk("t2_door3", int'(door_open), 1);
    tick();
    chk("t2_closed", int'(door_open), 0);
    chk("t2_idle_mh", int'(move_handler), 0);

    // Request at the current floor: door without movement
    do_reset();
    led[0] = 1'b1; gf = 2'd2;
    tick();
    chk("t3_door", int'(door_open), 1);
    chk("t3_clr1", int'(clr), 1);
    chk("t3_still", int'({up, down}), 0);
    chk("t3_floor", int'(floor), 0);
    tick();
    chk("t3_clr_off", int'(clr), 0);
    tick();
    chk("t3_door3", int'(door_open), 1);
    tick();
    chk("t3_idle", int'(move_handler), 0);

    // gf and led2 change mid-transit; target stays F3, then F2 is served downward
    do_reset();
    led[2] = 1'b1; gf = 2'd2;
    tick();
    tick();
    gf = 2'd1; led[1] = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      chk("t4_up", int'(up), 1);
      chk("t4_floor", int'(floor), (i < 4) ? 0 : 1);
      chk("t4_pass_f2", int'(door_open), 0);
    end
    tick();
    chk("t4_at_f3", int'(floor), 2);
    chk("t4_clr3", int'(clr), 4);
    tick();
    tick();
    tick();
    chk("t4_idle", int'(move_handler), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_down", int'(down), 1);
      chk("t4_down_floor", int'(floor), 2);
    end
    tick();
    chk("t4_at_f2", int'(floor), 1);
    chk("t4_door_f2", int'(door_open), 1);
    chk("t4_clr2", int'(clr), 2);

    // Door re-extension at F2
    tick();
    chk("t5_door_c2", int'(door_open), 1);
    led[1] = 1'b1;
    tick();
    chk("t5_clr2_again", int'(clr), 2);
    chk("t5_door_ext1", int'(door_open), 1);
    tick();
    chk("t5_door_ext2", int'(door_open), 1);
    tick();
    chk("t5_door_ext3", int'(door_open), 1);
    tick();
    chk("t5_closed", int'(door_open), 0);

    // Invalid goal floor keeps the car idle
    do_reset();
    led[1] = 1'b1; gf = 2'd3;
    repeat (3) tick();
    chk("t6_mh", int'(move_handler), 0);
    chk("t6_dir", int'({up, down}), 0);
    chk("t6_floor", int'(floor), 0);

    // Asynchronous reset mid-transit
    do_reset();
    led[2] = 1'b1; gf = 2'd2;
    repeat (6) tick();
    chk("t1_pre_floor", int'(floor), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_async_floor", int'(floor), 0);
    chk("t1_async_outs", int'({move_handler, up, down, door_open, clr}), 0);
    led = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 9) == 0) led[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) gf = 2'($urandom_range(0, 3));
    end

    tick();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
